// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle logical left shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } shift_state_t;

  localparam int SHAMT_W = 5;
  localparam int STAGES  = 5;

  // Stage k shifts by 16, 8, 4, 2, 1 for k = 0..4.
  function automatic logic [SHAMT_W-1:0] stage_amount(input logic [2:0] k);
    return 5'd16 >> k;
  endfunction

endpackage

// File: rtl/sll_stage.sv
// One conditional power-of-two left-shift stage; the top reuses it every cycle.
module sll_stage
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] data,
  input  logic         en,
  input  logic [2:0]   k,
  output logic [N-1:0] q
);

  assign q = en ? (data << stage_amount(k)) : data;

endmodule

// File: rtl/shift_left_logical_seq.sv
// Multi-cycle sll: one conditional power-of-two stage per clock (16, 8, 4, 2, 1),
// valid/ready on both sides, fixed five-cycle latency.
module shift_left_logical_seq
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [N-1:0] shamt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  localparam logic [2:0] LAST_K = 3'(STAGES - 1);

  shift_state_t         state_reg;
  logic [2:0]           k_reg;
  logic [N-1:0]         data_reg;
  logic [SHAMT_W-1:0]   amt_reg;
  logic [N-1:0]         stage_q;
  logic                 unused_shamt_hi;

  // Only the low SHAMT_W bits of shamt select the shift; the rest are don't-care.
  assign unused_shamt_hi = ^shamt[N-1:SHAMT_W];

  sll_stage #(.N(N)) u_stage (
    .data (data_reg),
    .en   (amt_reg[LAST_K - k_reg]),
    .k    (k_reg),
    .q    (stage_q)
  );

  assign in_ready  = (state_reg == S_IDLE) || (state_reg == S_DONE && out_ready);
  assign out_valid = (state_reg == S_DONE);
  assign busy      = (state_reg != S_IDLE);
  assign out       = data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      k_reg     <= '0;
      data_reg  <= '0;
      amt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            data_reg  <= in;
            amt_reg   <= shamt[SHAMT_W-1:0];
            k_reg     <= '0;
            state_reg <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          data_reg <= stage_q;
          // Park k at 0 on leaving so it never indexes past the last stage.
          if (k_reg == LAST_K) begin
            k_reg     <= '0;
            state_reg <= S_DONE;
          end else begin
            k_reg <= k_reg + 3'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            if (in_valid) begin
              data_reg  <= in;
              amt_reg   <= shamt[SHAMT_W-1:0];
              k_reg     <= '0;
              state_reg <= S_SHIFT;
            end else begin
              state_reg <= S_IDLE;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_left_logical_seq.md
Name: shift_left_logical_seq

Overview:
- Multi-cycle logical left shifter, the opposite direction to the combinational right shifter.
- Takes one operand and a shift amount through a valid/ready handshake.
- Applies the shift as five conditional power-of-two stages, one stage per clock (16, 8, 4, 2, 1).
- Returns the result through a valid/ready handshake. Sits beside the ALU shift path for multi-cycle sll.

Parameters:
- N, 32, operand and result width. Used as a constant only; the design is verified at 32.
- SHAMT_W, 5, number of significant shamt bits, equal to log2(N). Also equals the stage count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- in_valid  input  1  operand and shamt are valid.
- in_ready  output  1  block can accept an operand this cycle.
- in  input  N  operand.
- shamt  input  N  shift amount. Only shamt[SHAMT_W-1:0] is used; upper bits are ignored.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer accepts the result.
- out  output  N  shifted result.
- busy  output  1  high in S_SHIFT or S_DONE.

Behaviour:
- States: S_IDLE, S_SHIFT, S_DONE. A 3-bit stage counter k runs 0..4.
- Reset (rst==0, asynchronous):
  - state=S_IDLE, k=0, internal data register=0, latched shamt=0.
  - out=0, out_valid=0, busy=0, in_ready=1 once state is S_IDLE.
- in_ready = (state==S_IDLE) || (state==S_DONE && out_ready).
- Accept: in_valid && in_ready at a rising edge.
  - Latch data<=in and amt<=shamt[4:0], set k<=0, go to S_SHIFT.
- S_SHIFT, each edge:
  - data <= amt[4-k] ? (data << (16>>k)), zero-filled : data.
  - k<=k+1. After the edge with k==4, go to S_DONE.
- S_DONE:
  - out_valid=1, out=data; out is stable while out_valid && !out_ready.
  - On out_valid && out_ready: if in_valid in the same cycle, accept the new operand and go to S_SHIFT (back-to-back); otherwise go to S_IDLE.
- Latency: operand accepted at edge E, out_valid visible after edge E+5. This is fixed regardless of amt, including amt==0.
- Throughput: one result per 6 cycles with continuous in_valid/out_ready.
- out drives data in all states; it is only meaningful when out_valid=1. out_valid is low in S_IDLE and S_SHIFT.
- in_valid during S_SHIFT is ignored (in_ready=0). Inputs need not be held after acceptance.
- Width rules:
  - Shift amounts 0..31 only. Bits shifted past bit N-1 are discarded; vacated low bits are 0.
  - shamt=32 (bit 5 set, low bits 0) shifts by 0.
- Reset mid-operation in S_SHIFT or S_DONE aborts immediately to reset values; the pending result is lost.
- No X on outputs after reset; no combinational path from in to out.

Decomposition:
- Package shift_pkg:
  - state enum shift_state_t {S_IDLE, S_SHIFT, S_DONE}.
  - localparam SHAMT_W=5 and STAGES=5.
  - function stage_amount(k) returning 16>>k.
- Sub-module sll_stage:
  - Combinational; inputs data[N-1:0], en, k[2:0]; output shifted data.
  - Instantiated once and reused every cycle, driven by k and amt[4-k].
- Top-level module: FSM, counter, registers, handshake.

Test Plan:
- Reset then basic shift: in=32'h0000_0001, shamt=5'd31 -> out_valid after 5 edges, out=32'h8000_0000; in_ready=0 during S_SHIFT.
- Zero and all-stage amounts:
  - in=32'hDEAD_BEEF, shamt=0 -> out=32'hDEAD_BEEF after 5 edges.
  - shamt=5'd31 -> out=32'h8000_0000.
  - shamt=5'd4 -> out=32'hEADB_EEF0.
- Upper shamt bits ignored: in=32'hFFFF_FFFF, shamt=32'h0000_0028 (low bits 8) -> out=32'hFFFF_FF00.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out stay constant, in_ready=0. Then raise out_ready with in_valid (in=32'h1, shamt=1) -> same-edge accept, next out=32'h2 five edges later.
- Reset mid-operation: assert rst=0 two cycles after accept -> out=0, out_valid=0, busy=0 immediately. After release, a new operand (32'h3, shamt=2) yields 32'hC.
- Random sweep: 1000 random in/shamt pairs with random out_ready stalls -> out equals in << shamt[4:0] against a reference model; latency is always 5.
